// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder that reuses one full-adder cell (two half-adder
// stages) over WIDTH cycles, LSB first, with a start/busy/done handshake.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_h1s;
    logic             w_h1c;
    logic             w_h2s;
    logic             w_h2c;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == CNT_LAST);

    // Shared full-adder cell: two half-adder stages on the current LSBs and carry.
    assign w_h1s       = r_sa[0] ^ r_sb[0];
    assign w_h1c       = r_sa[0] & r_sb[0];
    assign w_h2s       = w_h1s ^ r_carry;
    assign w_h2c       = w_h1s & r_carry;
    assign w_carry_nxt = w_h1c | w_h2c;

    // New sum bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
    assign w_acc_nxt = (r_acc >> 1) | (WIDTH'(w_h2s) << (WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the handshake flops switch on the same edge.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt != ST_IDLE) w_busy_nxt = 1'b1;
        if (w_state_nxt == ST_DONE) w_done_nxt = 1'b1;
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand shift registers, carry flop, partial-sum accumulator and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= cin;
        end else if (w_run) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_carry_nxt;
        end
    end

    // Result capture only on the completion edge; partial sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_acc_nxt;
            r_cout <= w_carry_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=8 main instance, WIDTH=1 side instance).
module tb_serial_add_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic       sum1;
    logic       cout1;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_seq #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_seq #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One full transaction on the WIDTH=8 instance; operands are scrambled while busy.
    task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] esum, input logic ecout, input string nm);
        int k;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = 8'($urandom); cin = ~tc;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, 32'(k), 32'd9);
        chk({nm, " sum"}, 32'(sum), 32'(esum));
        chk({nm, " cout"}, 32'(cout), 32'(ecout));
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(done), 32'd0);
        chk({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [8:0] ref9;
        logic [1:0] ref2;
        int         k;
        int         ndone;
        int         last;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset w1 busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 5; i++) begin
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].esum, vecs[i].ecout,
                   $sformatf("vec%0d", i));
        end

        // Random operands against plain-arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref9 = 9'(ra) + 9'(rb) + 9'(rc);
            do_add(ra, rb, rc, ref9[7:0], ref9[8], $sformatf("rand%0d", i));
        end

        // Start pulses during RUN and DONE are ignored; first IDLE start is accepted.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int kk = 1; kk <= 12; kk++) begin
            if (kk > 1) @(negedge clk);
            if (done) begin
                ndone++;
                chk("ign done cycle", 32'(kk), 32'd9);
                chk("ign sum", 32'(sum), 32'h30);
            end
            if (kk == 10) chk("ign idle gap", 32'(busy), 32'd0);
            if (kk == 11) chk("ign reaccept", 32'(busy), 32'd1);
            if (kk == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            if (kk == 4) start = 1'b0;
            if (kk == 9) start = 1'b1;
            if (kk == 11) start = 1'b0;
        end
        chk("ign one pulse", 32'(ndone), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ign second sum", 32'(sum), 32'hFF);
        chk("ign second cout", 32'(cout), 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-operation at cnt=4.
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int kk = 0; kk < 15; kk++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst no late done", 32'(ndone), 32'd0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "post-rst");

        // Continuous start: one result every WIDTH+2 cycles, stable between pulses.
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        ndone = 0; last = -1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("cont period", 32'(i - last), 32'd10);
                last = i;
                ndone++;
            end
            if (ndone > 0) chk("cont sum stable", 32'(sum), 32'h07);
        end
        start = 1'b0;
        chk("cont pulse count", 32'(ndone), 32'd4);
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cont drain", 32'(busy), 32'd0);

        // WIDTH=1 instance: exhaustive over all operand combinations.
        for (int i = 0; i < 8; i++) begin
            ref2 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
            @(negedge clk);
            a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2); start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            k = 1;
            while (!done1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("w1 latency %0d", i), 32'(k), 32'd2);
            chk($sformatf("w1 sum %0d", i), 32'(sum1), 32'(ref2[0]));
            chk($sformatf("w1 cout %0d", i), 32'(cout1), 32'(ref2[1]));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
